// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, output payload and bit-timing helpers.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              ferr;
  } rx_out_t;

  // Clock cycles in one full UART bit.
  function automatic logic [CNT_W-1:0] bit_cycles(input int unsigned clk_per_half_bit);
    return CNT_W'(2 * clk_per_half_bit);
  endfunction

  // Clock cycles in half a UART bit.
  function automatic logic [CNT_W-1:0] half_cycles(input int unsigned clk_per_half_bit);
    return CNT_W'(clk_per_half_bit);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to INIT.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= INIT;
      sync_q <= INIT;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-glitch rejection, framing-error pulse and break hold-off.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 100
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic [DATA_W-1:0] rdata,
  output logic              rx_ready,
  output logic              ferr,
  output logic              rx_busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] SKEW = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] SKEW = CNT_W'(0);
`endif

  localparam logic [CNT_W-1:0] HALF      = half_cycles(CLK_PER_HALF_BIT);
  localparam logic [CNT_W-1:0] BIT       = bit_cycles(CLK_PER_HALF_BIT);
  localparam logic [CNT_W-1:0] START_HIT = HALF - CNT_W'(1) + SKEW;
  localparam logic [CNT_W-1:0] BIT_HIT   = BIT - CNT_W'(1) + SKEW;

  logic rxs;
  logic sample_c;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              busy_q, busy_d;
  rx_out_t           out_q, out_d;

  sync_2ff #(
    .INIT(1'b1)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (rxd),
    .q   (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two synchronized samples; with rxs they span target-1..target+1 at decision time.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs};
    end
  end

  assign sample_c = maj3(hist_q[1], hist_q[0], rxs);
`else
  assign sample_c = rxs;
`endif

  // Next-state and output logic. After a mid-bit decision the counter restarts at SKEW,
  // so the bit spacing stays one full bit even when the decision is a cycle late.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shreg_d        = shreg_q;
    busy_d         = busy_q;
    out_d          = out_q;
    out_d.ready    = 1'b0;
    out_d.ferr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (!rxs) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end

      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == START_HIT) begin
          if (sample_c) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            cnt_d   = SKEW;
          end
        end
      end

      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_HIT) begin
          shreg_d = {sample_c, shreg_q[DATA_W-1:1]};
          idx_d   = IDX_W'(idx_q + IDX_W'(1));
          cnt_d   = SKEW;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_HIT) begin
          cnt_d = '0;
          if (sample_c) begin
            out_d.data  = shreg_q;
            out_d.ready = 1'b1;
            state_d     = IDLE;
            busy_d      = 1'b0;
          end else begin
            out_d.ferr = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end
      end

      // Line stuck low after a bad stop bit: wait for idle so a break is not read as 0x00 frames.
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  assign rdata    = out_q.data;
  assign rx_ready = out_q.ready;
  assign ferr     = out_q.ferr;
  assign rx_busy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLK_PER_HALF_BIT=8 (16-cycle bit period).
module tb_uart_rx;

  localparam int H   = 8;
  localparam int BIT = 2 * H;

`ifdef UART_RX_MAJORITY_EN
  localparam int         SKEW       = 1;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int         SKEW       = 0;
  localparam logic [7:0] GLITCH_EXP = 8'hFB;
`endif

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic [7:0] rdata;
  logic       rx_ready;
  logic       ferr;
  logic       rx_busy;

  uart_rx #(
    .CLK_PER_HALF_BIT(H)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rdata   (rdata),
    .rx_ready(rx_ready),
    .ferr    (ferr),
    .rx_busy (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int cyc            = 0;
  int ready_cnt      = 0;
  int ferr_cnt       = 0;
  int viol_cnt       = 0;
  int last_ready_cyc = 0;
  logic prev_ready   = 1'b0;
  logic prev_ferr    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: capture bytes and pulse-shape violations away from the active edge.
  always @(negedge clk) begin
    if (rx_ready) begin
      got_q.push_back(rdata);
      ready_cnt      = ready_cnt + 1;
      last_ready_cyc = cyc;
    end
    if (ferr) ferr_cnt = ferr_cnt + 1;
    if ((rx_ready && ferr) || (rx_ready && prev_ready) || (ferr && prev_ferr))
      viol_cnt = viol_cnt + 1;
    prev_ready = rx_ready;
    prev_ferr  = ferr;
  end

  logic [7:0] e, g;
  int c0, rc, fc;
  logic [7:0] rd_snap;

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_v);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop_v, stop_len);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    rstn = 1'b1;
    hold(1'b1, 4);
  endtask

  task automatic test_single;
    exp_q.push_back(8'h55);
    fc = ferr_cnt;
    c0 = cyc;
    send_frame(8'h55, BIT, 1'b1);
    hold(1'b1, 4);
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL single_byte: got no rx_ready expected %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL single_byte: got %h expected %h", g, e); end
      checks++;
      if (last_ready_cyc - c0 !== 3 + 19 * H + SKEW) begin
        errors++; $display("FAIL single_latency: got %0d expected %0d", last_ready_cyc - c0, 3 + 19 * H + SKEW);
      end
    end
    checks++; if (ferr_cnt !== fc) begin errors++; $display("FAIL single_ferr: got %0d expected %0d", ferr_cnt, fc); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    fc = ferr_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, BIT - 2, 1'b1);
    send_frame(8'h0F, BIT - 2, 1'b1);
    hold(1'b1, 2 * BIT);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL b2b_byte%0d: got no rx_ready expected %h", k, e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", k, g, e); end
      end
    end
    checks++; if (ferr_cnt !== fc) begin errors++; $display("FAIL b2b_ferr: got %0d expected %0d", ferr_cnt, fc); end
  endtask

  task automatic test_glitch;
    rc = ready_cnt;
    fc = ferr_cnt;
    rd_snap = rdata;
    hold(1'b0, 3);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", rx_busy); end
    hold(1'b1, H + 4);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", rx_busy); end
    hold(1'b1, 2 * BIT);
    checks++; if (ready_cnt !== rc) begin errors++; $display("FAIL glitch_ready: got %0d expected %0d", ready_cnt, rc); end
    checks++; if (ferr_cnt !== fc) begin errors++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, fc); end
    checks++; if (rdata !== rd_snap) begin errors++; $display("FAIL glitch_rdata: got %h expected %h", rdata, rd_snap); end
  endtask

  task automatic test_framing_error;
    rc = ready_cnt;
    fc = ferr_cnt;
    rd_snap = rdata;
    send_frame(8'h3C, 40, 1'b0);
    checks++; if (ferr_cnt !== fc + 1) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", ferr_cnt, fc + 1); end
    checks++; if (ready_cnt !== rc) begin errors++; $display("FAIL ferr_no_ready: got %0d expected %0d", ready_cnt, rc); end
    checks++; if (rdata !== rd_snap) begin errors++; $display("FAIL ferr_rdata: got %h expected %h", rdata, rd_snap); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line: got %b expected 1", rx_busy); end
    hold(1'b1, 6);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_idle: got %b expected 0", rx_busy); end
    hold(1'b1, BIT);
    exp_q.push_back(8'h81);
    send_frame(8'h81, BIT, 1'b1);
    hold(1'b1, BIT);
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL ferr_recover_byte: got no rx_ready expected %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL ferr_recover_byte: got %h expected %h", g, e); end
    end
    checks++; if (ferr_cnt !== fc + 1) begin errors++; $display("FAIL ferr_single_pulse: got %0d expected %0d", ferr_cnt, fc + 1); end
  endtask

  task automatic test_reset_mid_frame;
    rc = ready_cnt;
    fc = ferr_cnt;
    hold(1'b0, BIT);
    hold(1'b1, 4 * BIT);
    hold(1'b1, H);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", rx_busy); end
    rstn = 1'b0;
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h expected 00", rdata); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
    checks++; if ({rx_ready, ferr} !== 2'b00) begin errors++; $display("FAIL midrst_pulses: got %b expected 00", {rx_ready, ferr}); end
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    hold(1'b1, 2 * BIT);
    exp_q.push_back(8'h12);
    send_frame(8'h12, BIT, 1'b1);
    hold(1'b1, BIT);
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL midrst_next_byte: got no rx_ready expected %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL midrst_next_byte: got %h expected %h", g, e); end
    end
    checks++; if (ferr_cnt !== fc) begin errors++; $display("FAIL midrst_ferr: got %0d expected %0d", ferr_cnt, fc); end
    checks++; if (ready_cnt !== rc + 1) begin errors++; $display("FAIL midrst_ready_count: got %0d expected %0d", ready_cnt, rc + 1); end
  endtask

  task automatic test_sample_glitch;
    exp_q.push_back(GLITCH_EXP);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b1, BIT);
    hold(1'b1, H);
    hold(1'b0, 1);
    hold(1'b1, BIT - H - 1);
    hold(1'b1, 5 * BIT);
    hold(1'b1, BIT);
    hold(1'b1, BIT);
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL sample_glitch_byte: got no rx_ready expected %h", e); end
    else begin
      g = got_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL sample_glitch_byte: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_final;
    checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL pulse_shape: got %0d violations expected 0", viol_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL extra_bytes: got %0d unmatched expected 0", got_q.size()); end
  endtask

  initial begin
    rstn = 1'b0;
    rxd  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_sample_glitch();
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
